// File: rtl/comparator_serial_cascade.sv
// Serial cascade of 2-bit digit compare results (MSB digit first) into one wide gt/eq/lt result.
// Optional macro CMP_CASCADE_EARLY_TERM_EN: finish on the first deciding digit.
module comparator_serial_cascade #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic             lt_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             a_gt,
    output logic             a_eq,
    output logic             a_lt,
    output logic             err,
    output logic             busy,
    output logic [IDX_W-1:0] digit_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             run_gt_q, run_gt_d;
    logic             run_lt_q, run_lt_d;
    logic             err_d, in_ready_d, res_valid_d, busy_d;
    logic             a_gt_d, a_eq_d, a_lt_d;
    logic [IDX_W-1:0] digit_idx_d;
    logic             digit_gt, digit_lt, digit_eq, accept, decided, last, finish;

    assign digit_gt = gt_in & ~eq_in & ~lt_in;
    assign digit_lt = lt_in & ~gt_in & ~eq_in;
    assign digit_eq = eq_in & ~gt_in & ~lt_in;
    assign accept   = in_valid & in_ready;
    assign decided  = run_gt_q | run_lt_q;
    assign last     = (digit_idx == IDX_W'(NUM_DIGITS - 1));

`ifdef CMP_CASCADE_EARLY_TERM_EN
    assign finish = last | (~decided & (digit_gt | digit_lt));
`else
    assign finish = last;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        run_gt_d    = run_gt_q;
        run_lt_d    = run_lt_q;
        err_d       = err;
        digit_idx_d = digit_idx;
        a_gt_d      = a_gt;
        a_eq_d      = a_eq;
        a_lt_d      = a_lt;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    run_gt_d    = 1'b0;
                    run_lt_d    = 1'b0;
                    err_d       = 1'b0;
                    digit_idx_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    digit_idx_d = digit_idx + IDX_W'(1);
                    if (!decided) begin
                        run_gt_d = digit_gt;
                        run_lt_d = digit_lt;
                    end
                    // Malformed digits only flag the error; they count as equal.
                    if (!(digit_gt | digit_lt | digit_eq)) begin
                        err_d = 1'b1;
                    end
                    if (finish) begin
                        state_d = DONE;
                        a_gt_d  = run_gt_d;
                        a_lt_d  = run_lt_d;
                        a_eq_d  = ~(run_gt_d | run_lt_d);
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                    a_gt_d  = 1'b0;
                    a_eq_d  = 1'b0;
                    a_lt_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == RUN);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_gt_q  <= 1'b0;
            run_lt_q  <= 1'b0;
            err       <= 1'b0;
            digit_idx <= '0;
            a_gt      <= 1'b0;
            a_eq      <= 1'b0;
            a_lt      <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_gt_q  <= run_gt_d;
            run_lt_q  <= run_lt_d;
            err       <= err_d;
            digit_idx <= digit_idx_d;
            a_gt      <= a_gt_d;
            a_eq      <= a_eq_d;
            a_lt      <= a_lt_d;
            in_ready  <= in_ready_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_comparator_serial_cascade.sv
// Directed bench for comparator_serial_cascade (NUM_DIGITS=4); early-term vectors under CMP_CASCADE_EARLY_TERM_EN.
module tb_comparator_serial_cascade;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, in_ready;
    logic       gt_in, eq_in, lt_in, res_valid, res_ready;
    logic       a_gt, a_eq, a_lt, err, busy;
    logic [1:0] digit_idx;
    int         n_checks = 0;
    int         n_fail   = 0;

    comparator_serial_cascade #(.NUM_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in), .res_valid(res_valid), .res_ready(res_ready),
        .a_gt(a_gt), .a_eq(a_eq), .a_lt(a_lt), .err(err), .busy(busy), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic digit(input logic g, input logic e, input logic l);
        in_valid = 1'b1; gt_in = g; eq_in = e; lt_in = l;
        tick();
        in_valid = 1'b0; gt_in = 1'b0; eq_in = 1'b0; lt_in = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic g, input logic e, input logic l);
        chk({tag, "_valid"}, 32'(res_valid), 1);
        chk({tag, "_gt"}, 32'(a_gt), 32'(g));
        chk({tag, "_eq"}, 32'(a_eq), 32'(e));
        chk({tag, "_lt"}, 32'(a_lt), 32'(l));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        gt_in = 1'b0; eq_in = 1'b0; lt_in = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 0);
        chk("post_rst_idx", 32'(digit_idx), 0);
        chk("post_rst_a_eq", 32'(a_eq), 0);

`ifdef CMP_CASCADE_EARLY_TERM_EN
        // eq, gt -> decided on 2nd digit; later digits refused
        do_start();
        digit(1'b0, 1'b1, 1'b0);
        chk("et_wait", 32'(res_valid), 0);
        digit(1'b1, 1'b0, 1'b0);
        chk_result("et_gt", 1'b1, 1'b0, 1'b0);
        chk("et_in_ready", 32'(in_ready), 0);
        chk("et_idx", 32'(digit_idx), 2);
        digit(1'b0, 0, 1'b1);
        chk("et_idx_hold", 32'(digit_idx), 2);
        chk("et_gt_hold", 32'(a_gt), 1);
        take_result();
        chk("et_release", 32'(res_valid), 0);
        // lt on the first digit
        do_start();
        digit(1'b0, 1'b0, 1'b1);
        chk_result("et_lt", 1'b0, 1'b0, 1'b1);
        chk("et_lt_idx", 32'(digit_idx), 1);
        take_result();
        chk("et_lt_busy", 32'(busy), 0);
`else
        // A=10_01_11_00 B=10_01_10_11: eq,eq,gt,lt -> gt
        do_start();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_in_ready", 32'(in_ready), 1);
        digit(1'b0, 1'b1, 1'b0);
        digit(1'b0, 1'b1, 1'b0);
        digit(1'b1, 1'b0, 1'b0);
        chk("t1_not_yet", 32'(res_valid), 0);
        chk("t1_idx3", 32'(digit_idx), 3);
        digit(1'b0, 1'b0, 1'b1);
        chk_result("t1", 1'b1, 1'b0, 1'b0);
        chk("t1_err", 32'(err), 0);
        chk("t1_idx", 32'(digit_idx), 0);
        chk("t1_in_ready_done", 32'(in_ready), 0);
        start = 1'b1;
        take_result();
        start = 1'b0;
        chk("t1_valid_clr", 32'(res_valid), 0);
        chk("t1_gt_clr", 32'(a_gt), 0);
        chk("t1_start_in_done_ignored", 32'(busy), 0);
        tick();
        chk("t1_idle_stays", 32'(busy), 0);

        // A=B=8'hA5: all eq, result held under backpressure
        do_start();
        for (int i = 0; i < 4; i++) digit(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_result("t2_hold", 1'b0, 1'b1, 1'b0);
            tick();
        end
        chk_result("t2_hold_end", 1'b0, 1'b1, 1'b0);
        take_result();
        chk("t2_valid_clr", 32'(res_valid), 0);
        chk("t2_eq_clr", 32'(a_eq), 0);
        chk("t2_busy_clr", 32'(busy), 0);

        // A=8'h3F B=8'h40: lt,gt,gt,gt with an idle gap -> lt
        do_start();
        digit(1'b0, 1'b0, 1'b1);
        tick();
        chk("t3_gap_idx", 32'(digit_idx), 1);
        for (int i = 0; i < 3; i++) digit(1'b1, 1'b0, 1'b0);
        chk_result("t3", 1'b0, 1'b0, 1'b1);
        take_result();

        // gt+eq at index 1 -> treated equal, err sticky until next start
        do_start();
        digit(1'b0, 1'b1, 1'b0);
        digit(1'b1, 1'b1, 1'b0);
        chk("t4_err_now", 32'(err), 1);
        digit(1'b0, 1'b1, 1'b0);
        digit(1'b0, 1'b1, 1'b0);
        chk_result("t4", 1'b0, 1'b1, 1'b0);
        chk("t4_err", 32'(err), 1);
        take_result();
        chk("t4_err_sticky", 32'(err), 1);
        do_start();
        chk("t4_err_cleared", 32'(err), 0);

        // Mid-compare reset; start in RUN and in_valid in IDLE are ignored
        digit(1'b0, 1'b0, 1'b0);
        digit(1'b1, 1'b0, 1'b0);
        chk("t5_idx2", 32'(digit_idx), 2);
        do_start();
        chk("t5_start_in_run_idx", 32'(digit_idx), 2);
        chk("t5_start_in_run_busy", 32'(busy), 1);
        chk("t5_err_pre", 32'(err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_in_ready", 32'(in_ready), 0);
        chk("t5_rst_idx", 32'(digit_idx), 0);
        chk("t5_rst_err", 32'(err), 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) digit(1'b1, 1'b0, 1'b0);
        chk("t5_idle_valid", 32'(res_valid), 0);
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_idx", 32'(digit_idx), 0);
        do_start();
        for (int i = 0; i < 4; i++) digit(1'b0, 1'b1, 1'b0);
        chk_result("t5_recover", 1'b0, 1'b1, 1'b0);
        take_result();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
